// File: rtl/log_sched_pkg.sv
// rtl/log_sched_pkg.sv - shared types and defaults for the log2 core scheduler
package log_sched_pkg;

    localparam int FRAC_BITS           = 5;
    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_LOG_LATENCY     = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts just after ptr
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    int idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                grant       = '0;
                grant[idx]  = 1'b1;
                grant_id    = ID_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/log_sched.sv
// rtl/log_sched.sv - round-robin scheduler for the shared multi-cycle log2 core (option: LOG_SCHED_ZERO_CHECK_EN)
module log_sched
    import log_sched_pkg::*;
#(
    parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int  NUM_REQ     = DEF_NUM_REQ,
    parameter int  LOG_LATENCY = DEF_LOG_LATENCY,
    localparam int ID_W        = $clog2(NUM_REQ),
    localparam int CNT_W       = $clog2(LOG_LATENCY) + 1
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [DATA_WIDTH-1:0]         log_number_o,
    input  logic [DATA_WIDTH-1:0]         log_result_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic                          rsp_err_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOG_LATENCY - 1);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_valid;
    logic               accept;
    logic               operand_zero;

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_arb (
        .req         (req_valid_i),
        .ptr         (ptr),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign operand_zero = (log_number_o == '0);
    assign rsp_valid_o  = (state == RESP);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = grant;
                if (grant_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
`ifdef LOG_SCHED_ZERO_CHECK_EN
                state_nxt = operand_zero ? RESP : WAIT;
`else
                state_nxt = WAIT;
`endif
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The operand is loaded straight into log_number_o at the handshake so the
    // core sees it one cycle earlier; it then stays untouched until the next grant.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr          <= ID_W'(NUM_REQ - 1);
            cnt          <= '0;
            log_number_o <= '0;
            rsp_data_o   <= '0;
            rsp_id_o     <= '0;
        end else begin
            if (accept) begin
                log_number_o <= req_data_i[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                rsp_id_o     <= grant_id;
                ptr          <= grant_id;
            end
            if (state == ISSUE) begin
                cnt <= '0;
`ifdef LOG_SCHED_ZERO_CHECK_EN
                if (operand_zero) begin
                    rsp_data_o <= '0;
                end
`endif
            end
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    rsp_data_o <= log_result_i;
                end
            end
        end
    end

`ifdef LOG_SCHED_ZERO_CHECK_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_err_o <= 1'b0;
        end else if (state == ISSUE) begin
            rsp_err_o <= operand_zero;
        end
    end
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule
